// File: rtl/idct_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : idct_mul_sched
// Brief    : Block sequencer for the configurable-precision IDCT multiplier
//            wrapper (LOAD -> ROW -> COL -> FLUSH) with product valid strobe.
//            Optional perf counters enabled by defining IDCT_SCHED_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module idct_mul_sched #(
    parameter int LOAD_LEN = 64,
    parameter int PASS_LEN = 64,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 9
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             apx_row,
    input  logic             apx_col,
    input  logic             stall,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] count0,
    output logic             racc,
    output logic             rapx,
    output logic             rstP,
    output logic             busy,
    output logic             out_valid,
`ifdef IDCT_SCHED_PERF_EN
    output logic [15:0]      apx_cycles,
    output logic [15:0]      stall_cycles,
`endif
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_ROW   = 3'b010,
        S_COL   = 3'b011,
        S_FLUSH = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] PASS_LAST  = CNT_W'(PASS_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(PIPE_LAT - 1);

    state_t              cur_state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                accept;
    logic                done_nxt;
    logic                rapx_nxt;
    logic                apx_row_q;
    logic                apx_col_q;
    logic                in_pass;
    logic                feed;
    logic [PIPE_LAT-1:0] vld_pipe;

    assign state   = cur_state;
    assign in_pass = (cur_state == S_ROW) || (cur_state == S_COL);
    assign feed    = in_pass && !stall;

    always_comb begin
        state_nxt = cur_state;
        count_nxt = count0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    count_nxt = '0;
                    accept    = 1'b1;
                end
            end
            S_LOAD: begin
                if (count0 == LOAD_LAST) begin
                    state_nxt = S_ROW;
                    count_nxt = '0;
                end else begin
                    count_nxt = count0 + CNT_W'(1);
                end
            end
            S_ROW, S_COL: begin
                if (!stall) begin
                    if (count0 == PASS_LAST) begin
                        state_nxt = (cur_state == S_ROW) ? S_COL : S_FLUSH;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count0 + CNT_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (count0 == FLUSH_LAST) begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                    done_nxt  = 1'b1;
                end else begin
                    count_nxt = count0 + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Mode flops are already latched by the time ROW is entered, so decode from them directly.
    always_comb begin
        rapx_nxt = 1'b0;
        case (state_nxt)
            S_ROW:          rapx_nxt = apx_row_q;
            S_COL, S_FLUSH: rapx_nxt = apx_col_q;
            default:        rapx_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cur_state <= S_IDLE;
            count0    <= '0;
            racc      <= 1'b1;
            rapx      <= 1'b0;
            rstP      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            apx_row_q <= 1'b0;
            apx_col_q <= 1'b0;
            vld_pipe  <= '0;
        end else begin
            cur_state <= state_nxt;
            count0    <= count_nxt;
            racc      <= (state_nxt == S_IDLE);
            rapx      <= rapx_nxt;
            rstP      <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
            vld_pipe  <= (vld_pipe << 1) | PIPE_LAT'(feed);
            if (accept) begin
                apx_row_q <= apx_row;
                apx_col_q <= apx_col;
            end
        end
    end

    assign out_valid = vld_pipe[PIPE_LAT-1];

`ifdef IDCT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            apx_cycles   <= '0;
            stall_cycles <= '0;
        end else if (accept) begin
            apx_cycles   <= '0;
            stall_cycles <= '0;
        end else if (in_pass) begin
            if (stall) begin
                if (stall_cycles != 16'hFFFF)
                    stall_cycles <= stall_cycles + 16'd1;
            end else if (rapx) begin
                if (apx_cycles != 16'hFFFF)
                    apx_cycles <= apx_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
